// File: rtl/load_store_unit_if.sv
// Request/response and DataMemory bus of the load/store unit.
// slave = the unit itself, master = execute stage plus DataMemory.
interface load_store_unit_if;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [1:0]  Req_Size;
  logic        Req_Signed;
  logic [31:0] Req_Address;
  logic [31:0] Req_Write_Data;
  logic        Resp_Valid;
  logic [31:0] Resp_Data;
  logic        Resp_Error;
  logic [31:0] Mem_Address;
  logic [31:0] Mem_Write_Data;
  logic        Sig_Mem_Write;
  logic        Sig_Mem_Read;
  logic [31:0] Mem_Read_Data;

  modport slave (
    input  Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Address, Req_Write_Data,
    input  Mem_Read_Data,
    output Req_Ready, Resp_Valid, Resp_Data, Resp_Error,
    output Mem_Address, Mem_Write_Data, Sig_Mem_Write, Sig_Mem_Read
  );

  modport master (
    output Req_Valid, Req_Write, Req_Size, Req_Signed, Req_Address, Req_Write_Data,
    output Mem_Read_Data,
    input  Req_Ready, Resp_Valid, Resp_Data, Resp_Error,
    input  Mem_Address, Mem_Write_Data, Sig_Mem_Write, Sig_Mem_Read
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store unit over a word-wide DataMemory; sub-word stores use RMW.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN (default build aligns silently).
module load_store_unit #(
  parameter int unsigned WORD_ADDR_BITS = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  load_store_unit_if.slave bus
);

  localparam int unsigned DATA_W    = 32;
  localparam logic [1:0]  SIZE_BYTE = 2'b00;
  localparam logic [1:0]  SIZE_HALF = 2'b01;

  typedef enum logic [2:0] {IDLE, READ, RMW_READ, WRITE, RESP} state_t;

  state_t              state_q, state_d;
  logic [1:0]          lane_q, lane_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                ready_q, ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_error_q, resp_error_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_wr_q, mem_wr_d;
  logic                mem_rd_q, mem_rd_d;

  // Upper byte-address bits do not reach DataMemory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.Req_Address[DATA_W-1:WORD_ADDR_BITS+2];

  // Pick the addressed lane out of a word and extend it to 32 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size,
                                                    input logic sgn);
    logic [DATA_W-1:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SIZE_BYTE: load_extend = {{24{sgn & sh[7]}}, sh[7:0]};
      SIZE_HALF: load_extend = {{16{sgn & sh[15]}}, sh[15:0]};
      default:   load_extend = word;
    endcase
  endfunction

  // Replace the addressed lane of the old word with the right-aligned store data.
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] data,
                                                    input logic [1:0] lane,
                                                    input logic [1:0] size);
    logic [DATA_W-1:0] mask;
    mask = ((size == SIZE_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << {lane, 3'b000};
    store_merge = (old & ~mask) | ((data << {lane, 3'b000}) & mask);
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      lane_q       <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wr_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      wdata_q      <= wdata_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wr_q     <= mem_wr_d;
      mem_rd_q     <= mem_rd_d;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    size_d       = size_q;
    signed_d     = signed_q;
    wdata_d      = wdata_q;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.Req_Valid) begin
          size_d     = bus.Req_Size;
          signed_d   = bus.Req_Signed;
          wdata_d    = bus.Req_Write_Data;
          mem_addr_d = 32'(bus.Req_Address[WORD_ADDR_BITS+1:2]);
          // Lane is forced to the natural alignment of the access size.
          if (bus.Req_Size == SIZE_BYTE)      lane_d = bus.Req_Address[1:0];
          else if (bus.Req_Size == SIZE_HALF) lane_d = {bus.Req_Address[1], 1'b0};
          else                                lane_d = 2'b00;

          if (!bus.Req_Write)                 state_d = READ;
          else if (bus.Req_Size[1]) begin
            state_d     = WRITE;
            mem_wdata_d = bus.Req_Write_Data;
          end else                            state_d = RMW_READ;
`ifdef LSU_MISALIGN_TRAP_EN
          if ((bus.Req_Size == SIZE_HALF && bus.Req_Address[0]) ||
              (bus.Req_Size[1] && bus.Req_Address[1:0] != 2'b00)) begin
            state_d      = RESP;
            mem_wdata_d  = mem_wdata_q;
            resp_data_d  = '0;
            resp_error_d = 1'b1;
          end
`endif
        end
      end
      READ: begin
        resp_data_d  = load_extend(bus.Mem_Read_Data, lane_q, size_q, signed_q);
        resp_error_d = 1'b0;
        state_d      = RESP;
      end
      RMW_READ: begin
        mem_wdata_d = store_merge(bus.Mem_Read_Data, wdata_q, lane_q, size_q);
        state_d     = WRITE;
      end
      WRITE: begin
        resp_data_d  = '0;
        resp_error_d = 1'b0;
        state_d      = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d      = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
    mem_rd_d     = (state_d == READ) || (state_d == RMW_READ);
    mem_wr_d     = (state_d == WRITE);
  end

  assign bus.Req_Ready      = ready_q;
  assign bus.Resp_Valid     = resp_valid_q;
  assign bus.Resp_Data      = resp_data_q;
  assign bus.Resp_Error     = resp_error_q;
  assign bus.Mem_Address    = mem_addr_q;
  assign bus.Mem_Write_Data = mem_wdata_q;
  assign bus.Sig_Mem_Write  = mem_wr_q;
  assign bus.Sig_Mem_Read   = mem_rd_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage between the execute stage and DataMemory. Accepts byte, halfword and word load/store requests on a byte address, converts them to word-wide DataMemory accesses, and returns one response per request. Sub-word stores use read-modify-write. Loads are sign- or zero-extended.

## Interface

Parameters:
- WORD_ADDR_BITS, default 8: number of word-index bits driven to DataMemory. The upper byte-address bits are ignored.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Req_Valid  input  1  request present
- Req_Ready  output  1  unit can accept a request
- Req_Write  input  1  1 = store, 0 = load
- Req_Size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is treated as word
- Req_Signed  input  1  sign-extend a sub-word load
- Req_Address  input  32  byte address
- Req_Write_Data  input  32  store data, right-aligned
- Resp_Valid  output  1  one-cycle response pulse
- Resp_Data  output  32  load result; 0 for stores
- Resp_Error  output  1  misaligned request, valid with Resp_Valid
- Mem_Address  output  32  word index, {zeros, Req_Address[WORD_ADDR_BITS+1:2]}
- Mem_Write_Data  output  32  merged word to DataMemory
- Sig_Mem_Write  output  1  DataMemory write strobe
- Sig_Mem_Read  output  1  DataMemory read strobe
- Mem_Read_Data  input  32  DataMemory read data, combinational from Mem_Address

## Operation

- States: IDLE, READ, RMW_READ, WRITE, RESP.
- IDLE: Req_Ready = 1. A request is accepted on a clock edge when Req_Valid = 1. On acceptance, latch address, size, signed, write flag and data, then go to:
  - READ for a load;
  - WRITE for a word store;
  - RMW_READ for a sub-word store.
- READ: Sig_Mem_Read = 1. Capture Mem_Read_Data at the clock edge, extract the lane, extend it, then go to RESP.
- RMW_READ: Sig_Mem_Read = 1. Capture the old word, then go to WRITE.
- WRITE: Sig_Mem_Write = 1. Mem_Write_Data is one of:
  - the store data, for a word store;
  - the old word with the addressed lane replaced, for a sub-word store.
  
  Then go to RESP.
- RESP: Resp_Valid = 1 for exactly one cycle, then go to IDLE. Req_Ready = 0 in every state except IDLE, so back-to-back requests are spaced by at least one IDLE cycle.
- Lane select:
  - byte lane = Address[1:0];
  - halfword lane = Address[1] (bits 15:0 or 31:16);
  - little-endian.
- Extension:
  - Req_Signed = 1 replicates the lane MSB;
  - Req_Signed = 0 zero-fills;
  - word loads are unaffected by Req_Signed.
- Sig_Mem_Read and Sig_Mem_Write are never high in the same cycle. Both are low in IDLE and RESP.
- Outputs are registered from state and latched data. There is no combinational path from Req_* to Mem_*, except through the latched address.

## Timing

- Reset values: state IDLE, Req_Ready 1, Resp_Valid 0, Resp_Data 0, Resp_Error 0, Mem_Address 0, Mem_Write_Data 0, Sig_Mem_Write 0, Sig_Mem_Read 0.
- Latency from the acceptance edge to Resp_Valid:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - trapped misaligned request: 1 cycle.
- Reset asserted in any state forces all outputs to their reset values immediately. Any in-flight access is dropped. A partially completed RMW does not write.
- Resp_Data and Resp_Error are held until the next response.

## Configuration

- LSU_MISALIGN_TRAP_EN defined:
  - A halfword with Address[0] = 1, or a word with Address[1:0] ≠ 0, goes directly IDLE → RESP.
  - No memory strobe is issued.
  - Resp_Error = 1 and Resp_Data = 0.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned low address bits are forced to the natural alignment: halfword clears bit 0, word clears bits 1:0.
  - The access proceeds normally and Resp_Error is always 0.

## Test plan

- Word store of 150 to 0x0C, then word load of 0x0C:
  - the store writes word 3 = 150 with Sig_Mem_Write high for exactly one cycle;
  - the load has Resp_Valid 2 cycles after acceptance with Resp_Data = 150.
- Memory word 3 = 0x11223344, byte store of 0xAB to 0x0D:
  - RMW_READ, then WRITE with Mem_Write_Data = 0x1122AB44;
  - Resp_Valid 3 cycles after acceptance.
- Memory word 3 = 0x1122AB44:
  - signed byte load at 0x0D → 0xFFFFFFAB;
  - unsigned byte load at 0x0D → 0x000000AB;
  - unsigned halfword load at 0x0E → 0x00001122.
- Word load at 0x0E:
  - with LSU_MISALIGN_TRAP_EN: Resp_Error = 1 one cycle after acceptance, and no Sig_Mem_Read;
  - without it: word 3 is read and Resp_Error = 0.
- Reset asserted during RMW_READ of a byte store to 0x0D:
  - outputs go to reset values immediately;
  - word 3 is unchanged;
  - Req_Ready = 1 after reset release.
- Req_Valid held high continuously across two loads:
  - the second request is accepted only in IDLE, after the first Resp_Valid;
  - exactly two Resp_Valid pulses occur.
